imem_port_arbiter: RTL and testbench
====================================

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the number of consecutive denied loader-request cycles before the loader is given a forced grant.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port f_req, input, 1 bit: fetch-stage read request.
REQ-005 SHALL have port f_addr, input, 32 bits: fetch byte address.
REQ-006 SHALL have port f_gnt, output, 1 bit: fetch granted this cycle (combinational).
REQ-007 SHALL have port f_stall, output, 1 bit: f_req & ~f_gnt, driven to the PC/IF stage.
REQ-008 SHALL have ports f_rvalid (output, 1 bit) and f_rdata (output, 32 bits): registered fetch read response.
REQ-009 SHALL have ports l_req, l_we and l_lock (each input, 1 bit): loader/debug request, write enable and burst lock.
REQ-010 SHALL have ports l_addr (input, 32 bits) and l_wdata (input, 32 bits): loader byte address and write data.
REQ-011 SHALL have port l_gnt, output, 1 bit: loader granted this cycle (combinational).
REQ-012 SHALL have ports l_rvalid (output, 1 bit), l_rdata (output, 32 bits) and l_err (output, 1 bit): registered loader response.
REQ-013 SHALL have ports mem_addr (output, 32 bits), mem_we (output, 1 bit) and mem_wdata (output, 32 bits): the shared instruction-memory port.
REQ-014 SHALL have port mem_rdata, input, 32 bits: memory read data, combinational from mem_addr and word-indexed by address[31:2].

Function
REQ-015 SHALL implement states S_SHARE and S_LOCK.
REQ-016 SHALL grant at most one requester per cycle; f_gnt & l_gnt SHALL never both be 1.
REQ-017 S_SHARE grant rule:
- l_gnt = l_req & (~f_req | starve_cnt == STARVE_MAX).
- Otherwise f_gnt = f_req.
REQ-018 S_LOCK grant rule: l_gnt = l_req and f_gnt = 0.
REQ-019 S_SHARE -> S_LOCK when l_gnt & l_lock.
REQ-020 S_LOCK -> S_SHARE at the end of any cycle in which l_lock = 0.
REQ-021 starve_cnt width SHALL be clog2(STARVE_MAX+1).
REQ-022 starve_cnt update rules:
- Increment, saturating at STARVE_MAX, when l_req & ~l_gnt.
- Clear to 0 when l_gnt or ~l_req.
REQ-023 Memory port drive rules:
- On f_gnt: mem_addr = f_addr, mem_we = 0.
- On l_gnt: mem_addr = l_addr, mem_wdata = l_wdata, mem_we = l_we & ~misaligned, where misaligned = l_addr[1:0] != 0.
- With no grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
REQ-024 Fetch response: one cycle after f_gnt, f_rvalid = 1 and f_rdata = the mem_rdata captured in the grant cycle. Otherwise f_rvalid = 0 and f_rdata holds its last value.
REQ-025 Loader response: one cycle after l_gnt, l_rvalid = 1 for both reads and writes.
- l_rdata = captured mem_rdata for an aligned read; l_rdata is unchanged for a write.
- l_err = misaligned; a misaligned access writes nothing.
REQ-026 Read latency SHALL be exactly 1 cycle, with back-to-back grants producing back-to-back rvalids.
REQ-027 Requesters SHALL hold req/addr/wdata stable until gnt; the arbiter SHALL NOT store unsent requests.
REQ-028 Simultaneous f_req & l_req in S_SHARE with starve_cnt < STARVE_MAX SHALL result in fetch winning.

Reset
REQ-029 While rst_n = 0, the block SHALL hold:
- State = S_SHARE, starve_cnt = 0.
- f_rvalid = 0, l_rvalid = 0, l_err = 0.
- f_rdata = 0, l_rdata = 0.
REQ-030 Reset assertion SHALL take effect immediately, including mid-lock or with a response pending. A pending response SHALL be dropped and SHALL NOT appear after release.
REQ-031 The first grant after reset release SHALL follow the S_SHARE rules.

Verification
REQ-032 Fetch only: f_req=1, f_addr=0x0,0x4,0x8 on consecutive cycles with mem[0..2]=0x08002083,0x00008133,0x13 -> f_rvalid on 3 consecutive cycles, data in order, f_stall=0.
REQ-033 Contention with STARVE_MAX=4: f_req and l_req held 1, l_addr=0x80 read -> f_gnt for 4 cycles, l_gnt on the 5th cycle, f_stall=1 that cycle, starve_cnt back to 0 afterwards.
REQ-034 Locked burst: l_lock=1, writes 0xA,0xB,0xC to 0x100,0x104,0x108 with f_req=1 -> three l_gnt, mem_we=1 each cycle, f_gnt=0 throughout, S_SHARE one cycle after l_lock=0, fetch granted the next cycle.
REQ-035 Misaligned access: loader write to l_addr=0x102 -> mem_we=0, l_rvalid=1 with l_err=1 next cycle, memory unchanged.
REQ-036 Reset mid-lock: rst_n=0 during S_LOCK with l_rvalid pending -> rvalids 0 immediately; after release with f_req=l_req=1, fetch is granted first.
REQ-037 Invariant checks every cycle:
- f_gnt & l_gnt == 0.
- mem_we implies l_gnt.
- f_stall == f_req & ~f_gnt.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one instruction-memory port between fetch and a loader/debug master
// Fetch has priority unless the loader has starved for STARVE_MAX cycles; a locked loader burst excludes fetch.
module imem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_stall,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        l_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_SHARE, S_LOCK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt, starve_nxt;
  logic          misaligned;
  logic          starved;

  assign misaligned = l_addr[1:0] != 2'b00;
  assign starved    = starve_cnt == CW'(STARVE_MAX);
  assign f_stall    = f_req & ~f_gnt;

  always_comb begin
    f_gnt      = 1'b0;
    l_gnt      = 1'b0;
    state_nxt  = state;
    starve_nxt = '0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      S_SHARE: begin
        l_gnt = l_req & (~f_req | starved);
        f_gnt = f_req & ~l_gnt;
        if (l_gnt & l_lock) state_nxt = S_LOCK;
      end
      S_LOCK: begin
        l_gnt = l_req;
        if (!l_lock) state_nxt = S_SHARE;
      end
      default: state_nxt = S_SHARE;
    endcase
    if (l_req & ~l_gnt) starve_nxt = starved ? starve_cnt : starve_cnt + 1'b1;
    if (f_gnt) begin
      mem_addr = f_addr;
    end else if (l_gnt) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
      // Misaligned loader accesses are reported through l_err and never reach memory.
      mem_we    = l_we & ~misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SHARE;
      starve_cnt <= '0;
      f_rvalid   <= 1'b0;
      f_rdata    <= '0;
      l_rvalid   <= 1'b0;
      l_rdata    <= '0;
      l_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      f_rvalid   <= f_gnt;
      if (f_gnt) f_rdata <= mem_rdata;
      l_rvalid   <= l_gnt;
      l_err      <= l_gnt & misaligned;
      if (l_gnt & ~l_we & ~misaligned) l_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed and randomized checks of imem_port_arbiter against a behavioural model
module tb_imem_port_arbiter;
  localparam int SM = 4;

  logic        clk, rst_n;
  logic        f_req, f_gnt, f_stall, f_rvalid;
  logic [31:0] f_addr, f_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  imem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_stall(f_stall),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory driven by the DUT port.
  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  // Reference model state.
  logic [31:0] model_mem [256];
  bit          m_locked;
  int          m_denied;
  bit          m_fv, m_lv, m_le;
  logic [31:0] m_fd, m_ld;
  bit          last_fg, last_lg;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_denied = 0;
    m_fv = 0; m_lv = 0; m_le = 0; m_fd = '0; m_ld = '0;
    last_fg = 0; last_lg = 0;
  endtask

  task automatic expect_gnt(input string tag, input logic ef, input logic el);
    #1;
    check({tag, "_fgnt"}, f_gnt, ef);
    check({tag, "_lgnt"}, l_gnt, el);
  endtask

  // One clock: called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    bit eg_f, eg_l, mis;
    int widx;
    @(negedge clk);
    mis  = l_addr[1:0] != 2'b00;
    widx = l_addr[9:2];
    if (m_locked) begin
      eg_l = l_req; eg_f = 0;
    end else begin
      eg_l = l_req && (!f_req || m_denied >= SM);
      eg_f = f_req && !eg_l;
    end
    check("f_gnt", f_gnt, eg_f);
    check("l_gnt", l_gnt, eg_l);
    check("f_stall", f_stall, f_req && !eg_f);
    check("mem_we", mem_we, eg_l && l_we && !mis);
    check("mem_addr", mem_addr, eg_f ? f_addr : (eg_l ? l_addr : 32'h0));
    if (!eg_f) check("mem_wdata", mem_wdata, eg_l ? l_wdata : 32'h0);
    check("f_rvalid", f_rvalid, m_fv);
    check("f_rdata", f_rdata, m_fd);
    check("l_rvalid", l_rvalid, m_lv);
    check("l_rdata", l_rdata, m_ld);
    check("l_err", l_err, m_le);
    @(posedge clk);
    #1;
    m_fv = eg_f;
    if (eg_f) m_fd = model_mem[f_addr[9:2]];
    m_lv = eg_l;
    m_le = eg_l && mis;
    if (eg_l && !mis) begin
      if (l_we) model_mem[widx] = l_wdata;
      else      m_ld = model_mem[widx];
    end
    m_denied = (l_req && !eg_l) ? ((m_denied + 1 > SM) ? SM : m_denied + 1) : 0;
    m_locked = m_locked ? l_lock : (eg_l && l_lock);
    last_fg = eg_f; last_lg = eg_l;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_lock = 0; l_addr = '0; l_wdata = '0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom; mem[i] = v; model_mem[i] = v;
    end
    mem[0] = 32'h08002083; mem[1] = 32'h00008133; mem[2] = 32'h00000013;
    model_mem[0] = 32'h08002083; model_mem[1] = 32'h00008133; model_mem[2] = 32'h00000013;
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_rvalid", f_rvalid, 0);
    check("rst_l_rvalid", l_rvalid, 0);
    check("rst_l_err", l_err, 0);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    rst_n = 1;

    // Fetch-only stream.
    f_req = 1; f_addr = 32'h0; cycle();
    f_addr = 32'h4; #1 check("fo_rv0", f_rvalid, 1); check("fo_d0", f_rdata, 32'h08002083); cycle();
    f_addr = 32'h8; #1 check("fo_rv1", f_rvalid, 1); check("fo_d1", f_rdata, 32'h00008133); cycle();
    f_req = 0;      #1 check("fo_rv2", f_rvalid, 1); check("fo_d2", f_rdata, 32'h00000013); cycle();

    // Contention: loader wins on the fifth cycle.
    f_req = 1; l_req = 1; l_we = 0; l_addr = 32'h80;
    for (int i = 0; i < 5; i++) begin
      f_addr = 32'(i * 4);
      expect_gnt("cont", i < 4, i == 4);
      cycle();
    end
    l_req = 0; f_addr = 32'h10; cycle();

    // Locked write burst.
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'h100; l_wdata = 32'hA;
    for (int k = 0; k < 8 && !last_lg; k++) cycle();
    check("burst_first_gnt", last_lg, 1);
    l_addr = 32'h104; l_wdata = 32'hB; expect_gnt("burst1", 0, 1); check("burst1_we", mem_we, 1); cycle();
    l_addr = 32'h108; l_wdata = 32'hC; expect_gnt("burst2", 0, 1); check("burst2_we", mem_we, 1); cycle();
    l_req = 0; l_we = 0; l_lock = 0; expect_gnt("unlock", 0, 0); cycle();
    expect_gnt("post_unlock", 1, 0); cycle();
    check("burst_mem0", mem[8'h40], 32'hA);
    check("burst_mem1", mem[8'h41], 32'hB);
    check("burst_mem2", mem[8'h42], 32'hC);

    // Misaligned write.
    f_req = 0; l_req = 1; l_we = 1; l_addr = 32'h102; l_wdata = 32'hDEAD;
    expect_gnt("mis", 0, 1); check("mis_we", mem_we, 0); cycle();
    l_req = 0; l_we = 0;
    #1 check("mis_rvalid", l_rvalid, 1); check("mis_err", l_err, 1); check("mis_mem", mem[8'h40], 32'hA);
    cycle();

    // Reset during a locked burst with a response pending.
    l_req = 1; l_lock = 1; l_we = 0; l_addr = 32'h104; cycle();
    f_req = 1; expect_gnt("lockrd", 0, 1);
    check("pend_rvalid", l_rvalid, 1);
    rst_n = 0;
    #1 check("mid_rst_lrv", l_rvalid, 0); check("mid_rst_frv", f_rvalid, 0);
    model_reset();
    @(posedge clk); #1;
    check("rst_no_resp", l_rvalid, 0);
    rst_n = 1; l_lock = 0;
    expect_gnt("after_rst", 1, 0);
    cycle();
    l_req = 0; f_req = 0; cycle();

    // Randomized traffic; requesters hold their request until granted.
    for (int n = 0; n < 400; n++) begin
      if (!(f_req && !last_fg)) begin
        f_req  = ($urandom % 3) != 0;
        f_addr = {22'h0, 8'($urandom), 2'b00};
      end
      if (!(l_req && !last_lg)) begin
        l_req   = ($urandom % 2) == 1;
        l_we    = ($urandom % 2) == 1;
        l_addr  = {22'h0, 8'($urandom), (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
        l_wdata = $urandom;
      end
      if (($urandom % 4) == 0) l_lock = ~l_lock;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
